// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, keeps one instruction-memory read in flight,
// and buffers returned words in a small FIFO whose head feeds the decoder.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int unsigned     PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CntW     = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  // StDrop: a read is still in flight but its data belongs to a flushed stream.
  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [INSTR_W-1:0] instr_mem_d [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_d [DEPTH];
  logic               push, pop;

  always_comb begin
    imem_req    = (state_q == StIdle) && (count_q < DepthCnt) && !redirect_valid && !rst;
    imem_addr   = pc_q;
    instr_valid = (count_q != '0) && !rst;
    instruction = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
    instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
    push        = (state_q == StWait) && imem_ack && !redirect_valid;
    pop         = instr_valid && !stall && !redirect_valid;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // An ack arriving with the redirect closes the in-flight read, so DROP is skipped.
      unique case (state_q)
        StIdle:  state_d = StIdle;
        StWait:  state_d = imem_ack ? StIdle : StDrop;
        StDrop:  state_d = imem_ack ? StIdle : StDrop;
        default: state_d = StIdle;
      endcase
    end else begin
      unique case (state_q)
        StIdle: begin
          if (imem_req) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + ADDR_W'(1);
            state_d  = StWait;
          end
        end
        StWait:  if (imem_ack) state_d = StIdle;
        StDrop:  if (imem_ack) state_d = StIdle;
        default: state_d = StIdle;
      endcase

      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]    = req_pc_q;
        wr_ptr_d              = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      instr_mem_q <= '{default: '0};
      pc_mem_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      instr_mem_q <= instr_mem_d;
      pc_mem_q    <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run checked against a
// stream model (expected PC sequence restarts at reset/redirect and counts up by one).
module tb_instr_fetch;

  localparam logic [15:0] ResetPc = 16'h0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] instr_pc;

  // Memory source: automatic responder or hand-driven ack, selected by mem_en.
  logic        mem_en = 1'b1;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        man_ack = 1'b0;
  logic [15:0] man_rdata = 16'h0;
  int          mem_lat = 1;
  int          total = 0;
  int          bad = 0;

  assign imem_ack   = mem_en ? mem_ack : man_ack;
  assign imem_rdata = mem_en ? mem_rdata : man_rdata;

  always #5 clk = ~clk;

  instr_fetch #(
    .ADDR_W  (16),
    .INSTR_W (16),
    .DEPTH   (2),
    .RESET_PC(ResetPc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .stall         (stall),
    .instr_valid   (instr_valid),
    .instruction   (instruction),
    .instr_pc      (instr_pc)
  );

  // Memory returns 16'h1000 + address, mem_lat cycles after the request cycle.
  initial begin
    bit          pending;
    int          rem;
    logic [15:0] req_addr;
    pending   = 1'b0;
    rem       = 0;
    req_addr  = 16'h0;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (!mem_en) pending = 1'b0;
      else if (imem_req) begin
        pending  = 1'b1;
        rem      = mem_lat;
        req_addr = imem_addr;
      end
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (pending) begin
        rem--;
        if (rem <= 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 16'h1000 + req_addr;
          pending   = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 2 time units into the first cycle after reset release.
  task automatic do_reset();
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    mem_en         = 1'b1;
    man_ack        = 1'b0;
    repeat (6) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      step();
      #1;
      if (instr_valid) ok = 1'b1;
    end
  endtask

  task automatic run_to_req(input logic [15:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      if (imem_req && imem_addr == a) ok = 1'b1;
      else begin
        step();
        #1;
      end
    end
  endtask

  task automatic test_reset();
    bit ok;
    mem_lat = 1;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0; mem_en = 1'b1;
    #1;
    total++;
    if ({imem_req, instr_valid, instruction, instr_pc} !== 34'h0) begin
      bad++;
      $display("FAIL reset_during: got req=%b v=%b i=%h pc=%h want all zero",
               imem_req, instr_valid, instruction, instr_pc);
    end
    repeat (6) step();
    total++;
    if ({imem_req, instr_valid, instruction, instr_pc} !== 34'h0) begin
      bad++;
      $display("FAIL reset_held: got req=%b v=%b i=%h pc=%h want all zero",
               imem_req, instr_valid, instruction, instr_pc);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL first_req: got req=%b addr=%h want req=1 addr=0000", imem_req, imem_addr);
    end
    step(); #1;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_early: got instr_valid=%b want 0", instr_valid);
    end
    step(); #1;
    total++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'h1000, 16'h0000}) begin
      bad++;
      $display("FAIL first_instr: got v=%b i=%h pc=%h want v=1 i=1000 pc=0000",
               instr_valid, instruction, instr_pc);
    end
    for (int k = 1; k <= 3; k++) begin
      wait_valid(ok);
      total++;
      if (!ok || instruction !== 16'(16'h1000 + k) || instr_pc !== 16'(k)) begin
        bad++;
        $display("FAIL seq_pc%0d: got ok=%b i=%h pc=%h want i=%h pc=%h",
                 k, ok, instruction, instr_pc, 16'(16'h1000 + k), 16'(k));
      end
    end
  endtask

  task automatic test_stall_fill();
    int n;
    bit ok;
    mem_lat = 3;
    do_reset();
    stall = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) n++;
      step(); #1;
    end
    total++;
    if (n != 2) begin
      bad++;
      $display("FAIL fill_reqs: got %0d requests want 2", n);
    end
    total++;
    if ({imem_req, instr_valid, instruction, instr_pc} !== {2'b01, 16'h1000, 16'h0000}) begin
      bad++;
      $display("FAIL fill_head: got req=%b v=%b i=%h pc=%h want req=0 v=1 i=1000 pc=0000",
               imem_req, instr_valid, instruction, instr_pc);
    end
    stall = 1'b0;
    #1;
    step(); #1;
    total++;
    if ({imem_req, imem_addr, instr_pc} !== {1'b1, 16'h0002, 16'h0001}) begin
      bad++;
      $display("FAIL unstall_req: got req=%b addr=%h pc=%h want req=1 addr=0002 pc=0001",
               imem_req, imem_addr, instr_pc);
    end
    wait_valid(ok);
    total++;
    if (!ok || {instruction, instr_pc} !== {16'h1002, 16'h0002}) begin
      bad++;
      $display("FAIL unstall_pc2: got ok=%b i=%h pc=%h want i=1002 pc=0002",
               ok, instruction, instr_pc);
    end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    mem_lat = 1;
    do_reset();
    run_to_req(16'h0005, ok);
    mem_en = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rw_setup: got no request for 0005 want request");
    end
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rw_no_issue: got imem_req=%b want 0", imem_req);
    end
    step();
    redirect_valid = 1'b0; man_ack = 1'b1; man_rdata = 16'h1005;
    #1;
    total++;
    if ({instr_valid, imem_req} !== 2'b00) begin
      bad++;
      $display("FAIL rw_drop: got v=%b req=%b want v=0 req=0", instr_valid, imem_req);
    end
    step();
    man_ack = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0040}) begin
      bad++;
      $display("FAIL rw_new_req: got req=%b addr=%h want req=1 addr=0040", imem_req, imem_addr);
    end
    mem_en = 1'b1;
    wait_valid(ok);
    total++;
    if (!ok || {instruction, instr_pc} !== {16'h1040, 16'h0040}) begin
      bad++;
      $display("FAIL rw_first: got ok=%b i=%h pc=%h want i=1040 pc=0040",
               ok, instruction, instr_pc);
    end
  endtask

  task automatic test_redirect_ack();
    bit ok;
    mem_lat = 1;
    do_reset();
    run_to_req(16'h0003, ok);
    mem_en = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL ra_setup: got no request for 0003 want request");
    end
    step();
    redirect_valid = 1'b1; redirect_pc = 16'h0010; man_ack = 1'b1; man_rdata = 16'h1003;
    #1;
    step();
    redirect_valid = 1'b0; man_ack = 1'b0;
    #1;
    total++;
    if ({instr_valid, imem_req, imem_addr} !== {2'b01, 16'h0010}) begin
      bad++;
      $display("FAIL ra_next: got v=%b req=%b addr=%h want v=0 req=1 addr=0010",
               instr_valid, imem_req, imem_addr);
    end
    mem_en = 1'b1;
    wait_valid(ok);
    total++;
    if (!ok || {instruction, instr_pc} !== {16'h1010, 16'h0010}) begin
      bad++;
      $display("FAIL ra_first: got ok=%b i=%h pc=%h want i=1010 pc=0010",
               ok, instruction, instr_pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem_lat = 1;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, 16'hFFFF}) begin
      bad++;
      $display("FAIL wrap_req: got req=%b addr=%h want req=1 addr=ffff", imem_req, imem_addr);
    end
    wait_valid(ok);
    total++;
    if (!ok || {instruction, instr_pc} !== {16'h0FFF, 16'hFFFF}) begin
      bad++;
      $display("FAIL wrap_ffff: got ok=%b i=%h pc=%h want i=0fff pc=ffff",
               ok, instruction, instr_pc);
    end
    wait_valid(ok);
    total++;
    if (!ok || {instruction, instr_pc} !== {16'h1000, 16'h0000}) begin
      bad++;
      $display("FAIL wrap_0000: got ok=%b i=%h pc=%h want i=1000 pc=0000",
               ok, instruction, instr_pc);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 1;
    do_reset();
    stall = 1'b1;
    step(); #1;
    step(); #1;
    mem_en = 1'b0;
    total++;
    if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0001, 1'b1}) begin
      bad++;
      $display("FAIL rm_setup: got req=%b addr=%h v=%b want req=1 addr=0001 v=1",
               imem_req, imem_addr, instr_valid);
    end
    step();
    rst = 1'b1;
    #1;
    step(); #1;
    total++;
    if ({instr_valid, imem_req, instruction, instr_pc} !== 34'h0) begin
      bad++;
      $display("FAIL rm_after_rst: got v=%b req=%b i=%h pc=%h want all zero",
               instr_valid, imem_req, instruction, instr_pc);
    end
    step();
    rst = 1'b0; man_ack = 1'b1; man_rdata = 16'hDEAD;
    #1;
    total++;
    if ({imem_req, imem_addr} !== {1'b1, ResetPc}) begin
      bad++;
      $display("FAIL rm_first_req: got req=%b addr=%h want req=1 addr=%h",
               imem_req, imem_addr, ResetPc);
    end
    step();
    man_ack = 1'b1; man_rdata = 16'h1000;
    #1;
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL rm_stray_ack: got instr_valid=%b want 0", instr_valid);
    end
    step();
    man_ack = 1'b0;
    #1;
    total++;
    if ({instr_valid, instruction, instr_pc} !== {1'b1, 16'h1000, ResetPc}) begin
      bad++;
      $display("FAIL rm_deliver: got v=%b i=%h pc=%h want v=1 i=1000 pc=%h",
               instr_valid, instruction, instr_pc, ResetPc);
    end
    stall  = 1'b0;
    mem_en = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] exp_pc, exp_fetch, h_instr, h_pc;
    bit          prev_redir, hold;
    int          pops;
    exp_pc     = ResetPc;
    exp_fetch  = ResetPc;
    prev_redir = 1'b0;
    hold       = 1'b0;
    h_instr    = 16'h0;
    h_pc       = 16'h0;
    pops       = 0;
    mem_lat    = 1;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      stall          = ($urandom_range(0, 99) < 40);
      redirect_valid = ($urandom_range(0, 99) < 4);
      redirect_pc    = 16'($urandom);
      mem_lat        = int'($urandom_range(1, 4));
      #1;
      if (prev_redir) begin
        total++;
        if (instr_valid !== 1'b0) begin
          bad++;
          $display("FAIL rnd_post_redirect: got instr_valid=%b want 0", instr_valid);
        end
      end
      if (hold) begin
        total++;
        if ({instr_valid, instruction, instr_pc} !== {1'b1, h_instr, h_pc}) begin
          bad++;
          $display("FAIL rnd_stall_hold: got v=%b i=%h pc=%h want v=1 i=%h pc=%h",
                   instr_valid, instruction, instr_pc, h_instr, h_pc);
        end
      end
      if (redirect_valid) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++;
          $display("FAIL rnd_redirect_req: got imem_req=%b want 0", imem_req);
        end
        exp_pc    = redirect_pc;
        exp_fetch = redirect_pc;
      end else begin
        if (instr_valid && !stall) begin
          total++;
          pops++;
          if ({instruction, instr_pc} !== {16'(16'h1000 + exp_pc), exp_pc}) begin
            bad++;
            $display("FAIL rnd_pop: got i=%h pc=%h want i=%h pc=%h",
                     instruction, instr_pc, 16'(16'h1000 + exp_pc), exp_pc);
          end
          exp_pc = exp_pc + 16'd1;
        end
        if (imem_req) begin
          total++;
          if (imem_addr !== exp_fetch) begin
            bad++;
            $display("FAIL rnd_fetch_addr: got %h want %h", imem_addr, exp_fetch);
          end
          exp_fetch = exp_fetch + 16'd1;
        end
      end
      prev_redir = redirect_valid;
      hold       = instr_valid && stall && !redirect_valid;
      h_instr    = instruction;
      h_pc       = instr_pc;
      step();
    end
    total++;
    if (pops < 20) begin
      bad++;
      $display("FAIL rnd_progress: got %0d pops want at least 20", pops);
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall_fill();
    test_redirect_wait();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
